// File: rtl/axis_pkg.sv
// Shared AXI-Stream width-conversion definitions, used by the upsizer and the future downsizer.
package axis_pkg;

    localparam int unsigned AXIS_WIDTH       = 8;
    localparam int unsigned AXIS_RATIO       = 4;
    localparam int unsigned AXIS_IDX_W       = $clog2(AXIS_RATIO);
    localparam int unsigned AXIS_MAX_WORD_W  = 1024;

    typedef logic [AXIS_IDX_W-1:0] lane_idx_t;

    // Replace lane `lane` (lane_w bits wide) of `word` with the low lane_w bits of `lane_data`.
    function automatic logic [AXIS_MAX_WORD_W-1:0] axis_merge_lane(
        input logic [AXIS_MAX_WORD_W-1:0] word,
        input logic [AXIS_MAX_WORD_W-1:0] lane_data,
        input int unsigned                lane,
        input int unsigned                lane_w
    );
        logic [AXIS_MAX_WORD_W-1:0] mask;
        mask = ((AXIS_MAX_WORD_W'(1) << lane_w) - AXIS_MAX_WORD_W'(1)) << (lane * lane_w);
        return (word & ~mask) | ((lane_data << (lane * lane_w)) & mask);
    endfunction

endpackage

// File: rtl/axis_upsizer.sv
// Packs RATIO narrow AXI-Stream beats into one wide word with keep flags; TLast closes a word early.
module axis_upsizer
    import axis_pkg::*;
#(
    parameter int unsigned WIDTH = AXIS_WIDTH,
    parameter int unsigned RATIO = AXIS_RATIO
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic [WIDTH-1:0]       S_TData,
    input  logic                   S_TValid,
    input  logic                   S_TLast,
    output logic                   S_TReady,
    output logic [WIDTH*RATIO-1:0] M_TData,
    output logic [RATIO-1:0]       M_TKeep,
    output logic                   M_TValid,
    output logic                   M_TLast,
    input  logic                   M_TReady,
    output logic                   isBusy,
    output logic [15:0]            PktCount
);

    localparam int unsigned WORD_W = WIDTH * RATIO;
    localparam int unsigned IDX_W  = $clog2(RATIO);

    logic [WORD_W-1:0] r_acc;
    logic [RATIO-1:0]  r_acc_keep;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_m_data;
    logic [RATIO-1:0]  r_m_keep;
    logic              r_m_last;
    logic              r_m_valid;
    logic [15:0]       r_pkt_count;

    logic              w_accept;
    logic              w_close;
    logic              w_out_fire;
    logic [WORD_W-1:0] w_merged;
    logic [RATIO-1:0]  w_merged_keep;

    // Ready only looks at the output slot, never at the input side.
    assign S_TReady   = Reset && (!r_m_valid || M_TReady);
    assign w_accept   = S_TValid && S_TReady;
    assign w_close    = w_accept && ((r_idx == IDX_W'(RATIO - 1)) || S_TLast);
    assign w_out_fire = r_m_valid && M_TReady;

    assign w_merged = WORD_W'(axis_merge_lane(AXIS_MAX_WORD_W'(r_acc), AXIS_MAX_WORD_W'(S_TData),
                                              32'(r_idx), WIDTH));
    assign w_merged_keep = r_acc_keep | (RATIO'(1) << r_idx);

    // Partial-word accumulator.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_acc      <= '0;
            r_acc_keep <= '0;
            r_idx      <= '0;
        end else if (w_accept) begin
            if (w_close) begin
                r_acc      <= '0;
                r_acc_keep <= '0;
                r_idx      <= '0;
            end else begin
                r_acc      <= w_merged;
                r_acc_keep <= w_merged_keep;
                r_idx      <= IDX_W'(r_idx + 1'b1);
            end
        end
    end

    // One-deep output slot; a closing word overwrites a word leaving on the same edge.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
        end else if (w_close) begin
            r_m_data  <= w_merged;
            r_m_keep  <= w_merged_keep;
            r_m_last  <= S_TLast;
            r_m_valid <= 1'b1;
        end else if (w_out_fire) begin
            r_m_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_pkt_count <= '0;
        end else if (w_out_fire && r_m_last) begin
            r_pkt_count <= r_pkt_count + 16'd1;
        end
    end

    assign M_TData  = r_m_data;
    assign M_TKeep  = r_m_keep;
    assign M_TLast  = r_m_last;
    assign M_TValid = r_m_valid;
    assign isBusy   = (r_idx != '0);
    assign PktCount = r_pkt_count;

endmodule

// File: doc/axis_upsizer.md
# axis_upsizer

Stream width upsizer on the consumer side of the 8-bit AXI-Stream `fifo`. It packs `RATIO` consecutive bytes from the FIFO's master port into one wide word with per-byte keep flags. A packet's final, partial word is closed early on `TLast`. The block gives downstream word-oriented logic full byte throughput and a one-deep registered output.

## Interface
Parameters:
- `WIDTH`, 8, input lane width in bits, matching the FIFO `width`.
- `RATIO`, 4, input beats per output word; must be ≥2 and a power of two.

Ports:
- `CLK`  input  1  single clock; all logic on its rising edge.
- `Reset`  input  1  asynchronous, active-low reset (0 = in reset).
- `S_TData`  input  WIDTH  input byte, driven from the FIFO `M_TData`.
- `S_TValid`  input  1  input beat valid.
- `S_TLast`  input  1  last byte of the packet.
- `S_TReady`  output  1  block accepts an input beat.
- `M_TData`  output  WIDTH*RATIO  packed word; lane 0 is bits [WIDTH-1:0].
- `M_TKeep`  output  RATIO  lane i holds a valid byte.
- `M_TValid`  output  1  output word valid.
- `M_TLast`  output  1  word ends a packet.
- `M_TReady`  input  1  downstream accepts the word.
- `isBusy`  output  1  a partial word is held (lane index ≠ 0).
- `PktCount`  output  16  count of packets emitted; wraps modulo 2^16.

## Operation
- Internal state:
  - accumulator `acc` (WIDTH*RATIO bits).
  - keep mask `accKeep` (RATIO bits).
  - lane index `idx` (log2(RATIO) bits).
  - output register: `M_TData`/`M_TKeep`/`M_TLast`/`M_TValid`.
- Input handshake: `S_TReady = Reset && (!M_TValid || M_TReady)`. `S_TReady` depends combinationally on `M_TReady` and on nothing else from the input side.
- Input beat accepted (`S_TValid && S_TReady`):
  - byte is written into lane `idx`, and `accKeep[idx]` is set.
  - the word closes if `idx == RATIO-1` or `S_TLast`.
- Word does not close: `idx` increments by 1.
- Word closes, on the same edge:
  - the merged word (acc plus the new byte) loads into the output register.
  - `M_TValid` goes to 1, and `M_TLast` takes the value of `S_TLast`.
  - `idx`, `acc` and `accKeep` clear to 0.
- Unused lanes of a closed word: data 0, keep 0. Keep is always a contiguous run of ones starting at lane 0.
- Output handshake:
  - `M_TValid && M_TReady` transfers the word.
  - If no new word closes on that edge, `M_TValid` drops to 0 and data, keep and last are held (don't-care).
  - If a new word closes on that edge, the new word replaces the old one with no bubble.
- Stall: while `M_TValid && !M_TReady`, the output register is frozen and `S_TReady` = 0, so no input beat is accepted and `acc` is held.
- `PktCount` increments on each handshake of a word with `M_TLast` = 1.

## Timing
- Reset (async assert, released synchronously by the system):
  - `M_TValid`=0, `M_TData`=0, `M_TKeep`=0, `M_TLast`=0.
  - `idx`=0, `acc`=0, `accKeep`=0.
  - `PktCount`=0, `isBusy`=0, `S_TReady`=0.
- Latency: the closing byte is accepted at edge k, and `M_TValid`=1 after edge k. This is 1 cycle, and the first full word appears RATIO cycles after its first byte.
- Throughput: 1 byte/cycle sustained while `M_TReady` is held at 1; no idle cycles, including across packet boundaries.
- Single-byte packet: accepted byte with `S_TLast` gives `M_TKeep`=…0001 and `M_TLast`=1.
- Reset asserted mid-packet or mid-stall: the partial word and the held output are discarded, with no output beat. The next accepted byte lands in lane 0.
- `PktCount` wraps from 0xFFFF to 0x0000.

## Structure
- A shared package `axis_pkg` holds:
  - default `WIDTH`/`RATIO` constants.
  - the `$clog2`-based lane-index width.
  - a lane-index typedef.
  - the helper function that merges a byte into lane i.
- The package is reused by the future downsizer.
- Single module; no sub-module.

## Test plan
- Bytes 0x01..0x08 with `S_TLast` on 0x08, `M_TReady`=1: words 0x04030201 (keep 0xF, last 0) and 0x08070605 (keep 0xF, last 1), back-to-back; `PktCount`=1.
- Packet 0xAA,0xBB,0xCC with last on 0xCC: 0x00CCBBAA, keep 0x7, last 1; the next packet's first byte lands in lane 0.
- One-byte packet 0x5A with last: 0x0000005A, keep 0x1, last 1, one cycle after acceptance.
- Backpressure: `M_TReady`=0 after the first word closes. Check:
  - `S_TReady`=0 and `M_TData` stable for 5 cycles.
  - on raising `M_TReady`, the stream resumes with no lost or duplicated byte.
- Reset pulled low after 2 bytes of a packet:
  - all outputs read 0 in the same cycle.
  - after release, bytes 0x10..0x13 give 0x13121110 with keep 0xF.
- 65536 one-byte packets: `PktCount` wraps to 0x0000.
